ir_seg_reg: RTL and testbench

Parametrised instruction register: the successor of the fixed 16-bit, two-half instruction register. The width is a whole number of bus-width segments. It loads in two ways: by indexed segment, or as a sequential, handshaked stream of segments, least-significant segment first. It keeps the clear, increment and decrement operations, and flags when a complete instruction has been assembled. It sits between the memory data bus and the control unit's decoder.

---
 rtl/ir_seg_reg.sv | 110 +++++++++++
 tb/tb_ir_seg_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ir_seg_reg.sv
// Segmented instruction register: indexed or streamed segment loads,
// clear/inc/dec, and an assembled-instruction flag for the decoder.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   e, funsel   : op enable; 00 clr, 01 idx load, 10 dec, 11 inc
//   seg_sel     : segment index for indexed load
//   i_seg       : segment data (both load modes)
//   seq_valid   : stream beat offered
//   seq_ready   : stream beat accepted this cycle if valid
//   ir_out      : register contents
//   ir_full     : all segments written since last clear/reset
//   seg_ptr     : next segment the stream writes
module ir_seg_reg #(
  parameter  int IR_WIDTH  = 16,
  parameter  int BUS_WIDTH = 8,
  localparam int NSEG      = IR_WIDTH / BUS_WIDTH,
  localparam int SEG_W     = $clog2(NSEG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 e,
  input  logic [1:0]           funsel,
  input  logic [SEG_W-1:0]     seg_sel,
  input  logic [BUS_WIDTH-1:0] i_seg,
  input  logic                 seq_valid,
  output logic                 seq_ready,
  output logic [IR_WIDTH-1:0]  ir_out,
  output logic                 ir_full,
  output logic [SEG_W-1:0]     seg_ptr
);

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    FULL
  } state_t;

  localparam logic [SEG_W-1:0] LAST = SEG_W'(NSEG - 1);

  state_t              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [NSEG-1:0]     mask_q, mask_d;
  logic [SEG_W-1:0]    ptr_q, ptr_d;
  logic                beat;

  assign seq_ready = !e && (state_q != FULL);
  assign beat      = seq_valid && seq_ready;
  assign ir_out    = ir_q;
  assign ir_full   = &mask_q;
  assign seg_ptr   = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    if (e) begin
      unique case (1'b1)
        (funsel == 2'b00): begin
          ir_d    = '0;
          mask_d  = '0;
          ptr_d   = '0;
          state_d = IDLE;
        end
        (funsel == 2'b01): begin
          // out-of-range index matches no segment
          for (int s = 0; s < NSEG; s++) begin
            if (seg_sel == SEG_W'(s)) begin
              ir_d[s*BUS_WIDTH +: BUS_WIDTH] = i_seg;
              mask_d[s] = 1'b1;
            end
          end
        end
        (funsel == 2'b10): ir_d = ir_q - IR_WIDTH'(1);
        (funsel == 2'b11): ir_d = ir_q + IR_WIDTH'(1);
        default: ;
      endcase
    end else if (beat) begin
      for (int s = 0; s < NSEG; s++) begin
        if (ptr_q == SEG_W'(s)) begin
          ir_d[s*BUS_WIDTH +: BUS_WIDTH] = i_seg;
          mask_d[s] = 1'b1;
        end
      end
      if (ptr_q == LAST) begin
        ptr_d   = '0;
        state_d = FULL;
      end else begin
        ptr_d   = ptr_q + SEG_W'(1);
        state_d = ASSEMBLE;
      end
    end
  end

endmodule

// File: tb/tb_ir_seg_reg.sv
// Directed bench for ir_seg_reg: a 16/8 instance and a 32/8
// instance driven from one linear sequence with hand-computed values.
module tb_ir_seg_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_e = 1'b0;
  logic [1:0] a_fs = 2'b00;
  logic [0:0] a_sel = 1'b0;
  logic [7:0] a_seg = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [15:0] a_ir;
  logic       a_full;
  logic [0:0] a_ptr;

  logic       b_e = 1'b0;
  logic [1:0] b_fs = 2'b00;
  logic [1:0] b_sel = 2'b00;
  logic [7:0] b_seg = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [31:0] b_ir;
  logic       b_full;
  logic [1:0] b_ptr;

  ir_seg_reg #(.IR_WIDTH(16), .BUS_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .e(a_e), .funsel(a_fs),
    .seg_sel(a_sel), .i_seg(a_seg), .seq_valid(a_valid),
    .seq_ready(a_ready), .ir_out(a_ir), .ir_full(a_full),
    .seg_ptr(a_ptr)
  );

  ir_seg_reg #(.IR_WIDTH(32), .BUS_WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .e(b_e), .funsel(b_fs),
    .seg_sel(b_sel), .i_seg(b_seg), .seq_valid(b_valid),
    .seq_ready(b_ready), .ir_out(b_ir), .ir_full(b_full),
    .seg_ptr(b_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic [1:0] fs, input logic sel,
                      input logic [7:0] d);
    a_e = 1'b1; a_fs = fs; a_sel = sel; a_seg = d;
    step();
    a_e = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d);
    b_valid = 1'b1; b_seg = d;
    step();
    b_valid = 1'b0;
  endtask

  task automatic b_clr();
    b_e = 1'b1; b_fs = 2'b00;
    step();
    b_e = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_a_ir", 32'(a_ir), 32'h0);
    chk("rst_a_full", 32'(a_full), 32'h0);
    chk("rst_a_ptr", 32'(a_ptr), 32'h0);
    chk("rst_a_ready", 32'(a_ready), 32'h1);
    chk("rst_b_ir", b_ir, 32'h0);
    chk("rst_b_ready", 32'(b_ready), 32'h1);
    #1 rst_n = 1'b1;

    a_op(2'b01, 1'b0, 8'hAA);
    chk("idx_lo", 32'(a_ir), 32'h00AA);
    chk("idx_lo_full", 32'(a_full), 32'h0);
    a_op(2'b01, 1'b1, 8'h33);
    chk("idx_both", 32'(a_ir), 32'h33AA);
    chk("idx_full", 32'(a_full), 32'h1);
    chk("idx_ptr", 32'(a_ptr), 32'h0);
    a_op(2'b00, 1'b0, 8'h00);
    chk("clr_ir", 32'(a_ir), 32'h0);
    chk("clr_full", 32'(a_full), 32'h0);

    a_op(2'b01, 1'b0, 8'hFF);
    a_op(2'b01, 1'b1, 8'hFF);
    chk("ffff", 32'(a_ir), 32'hFFFF);
    a_op(2'b11, 1'b0, 8'h00);
    chk("inc_wrap", 32'(a_ir), 32'h0000);
    chk("inc_full", 32'(a_full), 32'h1);
    a_op(2'b10, 1'b0, 8'h00);
    chk("dec_wrap", 32'(a_ir), 32'hFFFF);
    chk("dec_full", 32'(a_full), 32'h1);
    a_op(2'b10, 1'b0, 8'h00);
    chk("dec", 32'(a_ir), 32'hFFFE);

    b_beat(8'hF0);
    chk("seq1_ir", b_ir, 32'h000000F0);
    chk("seq1_ptr", 32'(b_ptr), 32'h1);
    chk("seq1_ready", 32'(b_ready), 32'h1);
    b_beat(8'h01);
    b_beat(8'h4C);
    chk("seq3_full", 32'(b_full), 32'h0);
    b_beat(8'h10);
    chk("seq4_ir", b_ir, 32'h104C01F0);
    chk("seq4_full", 32'(b_full), 32'h1);
    chk("seq4_ready", 32'(b_ready), 32'h0);
    chk("seq4_ptr", 32'(b_ptr), 32'h0);
    b_beat(8'h55);
    chk("seq5_ign", b_ir, 32'h104C01F0);
    chk("seq5_ptr", 32'(b_ptr), 32'h0);
    b_e = 1'b1; b_fs = 2'b00; #1;
    chk("e_ready", 32'(b_ready), 32'h0);
    step();
    b_e = 1'b0; #1;
    chk("clr32_ir", b_ir, 32'h0);
    chk("clr32_ready", 32'(b_ready), 32'h1);

    b_beat(8'h11);
    b_beat(8'h22);
    chk("cont_pre", b_ir, 32'h00002211);
    b_e = 1'b1; b_fs = 2'b11; b_valid = 1'b1; b_seg = 8'h33; #1;
    chk("cont_ready", 32'(b_ready), 32'h0);
    step();
    b_e = 1'b0;
    chk("cont_inc", b_ir, 32'h00002212);
    chk("cont_ptr", 32'(b_ptr), 32'h2);
    b_beat(8'h33);
    b_beat(8'h44);
    chk("cont_ir", b_ir, 32'h44332212);
    chk("cont_full", 32'(b_full), 32'h1);

    b_clr();
    b_beat(8'h99);
    chk("abort_ptr1", 32'(b_ptr), 32'h1);
    b_clr();
    chk("abort_ir", b_ir, 32'h0);
    chk("abort_ptr0", 32'(b_ptr), 32'h0);
    step();
    chk("hold_ir", b_ir, 32'h0);
    b_beat(8'hA1);
    b_beat(8'hB2);
    b_e = 1'b1; b_fs = 2'b01; b_sel = 2'd3; b_seg = 8'h77;
    step();
    b_e = 1'b0;
    chk("asm_idx", b_ir, 32'h7700B2A1);
    chk("asm_idx_ptr", 32'(b_ptr), 32'h2);
    b_beat(8'hC3);
    b_beat(8'hD4);
    chk("abort_ir2", b_ir, 32'hD4C3B2A1);
    chk("abort_ptr", 32'(b_ptr), 32'h0);
    chk("abort_ready", 32'(b_ready), 32'h0);
    chk("abort_full", 32'(b_full), 32'h1);

    #3 rst_n = 1'b0;
    #1;
    chk("arst_ir", b_ir, 32'h0);
    chk("arst_full", 32'(b_full), 32'h0);
    chk("arst_a_ir", 32'(a_ir), 32'h0);
    chk("arst_ready", 32'(b_ready), 32'h1);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
